// File: rtl/rv32im_dmem_if_if.sv
// Bundle of the execute-stage request, data-bus and writeback/exception
// signals of the RV32IM data-memory interface block. The block itself
// connects through the slave modport. The core/bus side (a testbench or
// wrapper) connects through the master modport.
interface rv32im_dmem_if_if;
  // Execute-stage request
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  // Data bus
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  // Writeback / retire / exception
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        done_o;
  logic        exc_valid_o;
  logic [1:0]  exc_cause_o;
  logic [31:0] exc_addr_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, req_rd_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, done_o, exc_valid_o, exc_cause_o,
           exc_addr_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i,
           req_wdata_i, req_rd_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
           wb_valid_o, wb_rd_o, wb_data_o, done_o, exc_valid_o, exc_cause_o,
           exc_addr_o
  );
endinterface

// File: rtl/rv32im_dmem_if.sv
// RV32IM load/store unit front end. It accepts one request at a time and
// checks its size and alignment. A legal request is issued as a
// word-aligned bus access with byte lanes. The block waits for the response
// with a timeout, then extends load data and retires the operation in a
// one-cycle DONE state.
module rv32im_dmem_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rv32im_dmem_if_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_e;

  localparam logic [1:0] CAUSE_MISALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL    = 2'b11;
  // The counter value at which one more response-less cycle would reach
  // TIMEOUT_CYCLES.
  localparam logic [7:0] TIMEOUT_LAST     = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        exc_q, exc_d;
  logic [1:0]  exc_cause_q, exc_cause_d;
  logic [31:0] exc_addr_q, exc_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  // Request fields captured on acceptance
  logic        we_q, unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [4:0]  rd_q;
  logic [3:0]  be_q;

  logic        accept;
  logic        chk_fail;
  logic [1:0]  chk_cause;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] rsp_shifted;
  logic [31:0] load_data;

  assign accept = bus.req_valid_i && (state_q == S_IDLE);

  // Size/alignment check of the incoming request. Illegal size wins.
  // NOTE: every always_comb output gets a default first so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    chk_fail  = 1'b1;
    chk_cause = CAUSE_ILLEGAL;
    case (bus.req_size_i)
      2'b00: chk_fail = 1'b0;
      2'b01: begin
        chk_fail  = bus.req_addr_i[0];
        chk_cause = CAUSE_MISALIGNED;
      end
      2'b10: begin
        chk_fail  = |bus.req_addr_i[1:0];
        chk_cause = CAUSE_MISALIGNED;
      end
      default: ;
    endcase
  end

  // Byte-lane enables and lane-replicated store data for the incoming request
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = bus.req_wdata_i;
    case (bus.req_size_i)
      2'b00: begin
        lane_be    = 4'b0001 << bus.req_addr_i[1:0];
        lane_wdata = {4{bus.req_wdata_i[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {bus.req_addr_i[1], 1'b0};
        lane_wdata = {2{bus.req_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Select and extend the addressed byte or half of the response word
  always_comb begin
    rsp_shifted = bus.mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_data   = bus.mem_rdata_i;
    case (size_q)
      2'b00: load_data = unsigned_q ? {24'h0, rsp_shifted[7:0]}
                                    : {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
      2'b01: load_data = unsigned_q ? {16'h0, rsp_shifted[15:0]}
                                    : {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
      default: ;
    endcase
  end

  // Next-state logic: transaction sequencing, timeout, result capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exc_d       = exc_q;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          exc_d = chk_fail;
          if (chk_fail) begin
            state_d     = S_DONE;
            exc_cause_d = chk_cause;
            exc_addr_d  = bus.req_addr_i;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = S_RSP;
          cnt_d   = 8'd0;
        end
      end
      S_RSP: begin
        // A response in the final allowed cycle still beats the timeout.
        if (bus.mem_rvalid_i) begin
          state_d = S_DONE;
          if (!we_q) begin
            wb_data_d = load_data;
            wb_rd_d   = rd_q;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_DONE;
          exc_d       = 1'b1;
          exc_cause_d = CAUSE_TIMEOUT;
          exc_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      exc_q       <= 1'b0;
      exc_cause_q <= '0;
      exc_addr_q  <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      we_q        <= 1'b0;
      unsigned_q  <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_q        <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exc_q       <= exc_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      if (accept) begin
        we_q       <= bus.req_we_i;
        unsigned_q <= bus.req_unsigned_i;
        size_q     <= bus.req_size_i;
        addr_q     <= bus.req_addr_i;
        wdata_q    <= lane_wdata;
        rd_q       <= bus.req_rd_i;
        be_q       <= lane_be;
      end
    end
  end

  // Bus fields come straight from registers, so they stay stable while the
  // grant is withheld.
  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.mem_req_o   = (state_q == S_REQ);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = {addr_q[31:2], 2'b00};
  assign bus.mem_be_o    = be_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.done_o      = (state_q == S_DONE);
  assign bus.exc_valid_o = (state_q == S_DONE) && exc_q;
  assign bus.exc_cause_o = exc_cause_q;
  assign bus.exc_addr_o  = exc_addr_q;
  assign bus.wb_valid_o  = (state_q == S_DONE) && !exc_q && !we_q && (rd_q != 5'd0);
  assign bus.wb_rd_o     = wb_rd_q;
  assign bus.wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_rv32im_dmem_if.sv
// Scoreboard bench for rv32im_dmem_if. It runs with TIMEOUT_CYCLES=4. The
// driver issues directed requests and pushes the expected bus access and the
// expected retire result. A bus responder/monitor and a retire monitor pop
// those queues and compare them against what the DUT presents.
module tb_rv32im_dmem_if;

  typedef struct {
    int          done_cyc;
    bit          exc;
    logic [1:0]  cause;
    logic [31:0] eaddr;
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  logic clk;
  logic rst_ni;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  rsp_t rsp_q[$];
  bus_t bus_q[$];

  // Bus responder configuration
  int          gnt_delay = 0;
  int          rsp_delay = 0;   // negative: never respond
  logic [31:0] rsp_data  = '0;
  bit          stray_rvalid = 1'b0;

  rv32im_dmem_if_if bus ();

  rv32im_dmem_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=time limit reached required=run complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bus_t b(input bit we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
    bus_t r;
    r.we = we; r.addr = addr; r.be = be; r.wdata = wdata;
    return r;
  endfunction

  function automatic rsp_t r_ok(input bit wb, input logic [4:0] rd, input logic [31:0] data);
    rsp_t r;
    r.done_cyc = 0; r.exc = 1'b0; r.cause = '0; r.eaddr = '0;
    r.wb = wb; r.rd = rd; r.data = data;
    return r;
  endfunction

  function automatic rsp_t r_exc(input logic [1:0] cause, input logic [31:0] eaddr);
    rsp_t r;
    r.done_cyc = 0; r.exc = 1'b1; r.cause = cause; r.eaddr = eaddr;
    r.wb = 1'b0; r.rd = '0; r.data = '0;
    return r;
  endfunction

  // Wait (bounded) until the DUT is idle, then set the bus responder behaviour.
  task automatic cfg(input int g, input int r, input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!bus.req_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready_o) check("idle_wait", 32'(bus.req_ready_o), 32'd1);
    gnt_delay = g;
    rsp_delay = r;
    rsp_data  = d;
  endtask

  // Present one request for one cycle and queue its expectations. The
  // request is accepted at the edge ending cycle T = cyc. The retire result
  // is expected in cycle T+lat.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] rd, input int lat,
                       input bit has_bus, input bus_t eb,
                       input bit has_rsp, input rsp_t er);
    rsp_t e;
    int   waited;
    e = er;
    waited = 0;
    while (!bus.req_ready_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready_o) begin
      check("ready_wait", 32'(bus.req_ready_o), 32'd1);
    end else begin
      bus.req_valid_i    = 1'b1;
      bus.req_we_i       = we;
      bus.req_size_i     = size;
      bus.req_unsigned_i = uns;
      bus.req_addr_i     = addr;
      bus.req_wdata_i    = wdata;
      bus.req_rd_i       = rd;
      e.done_cyc = cyc + lat;
      if (has_bus) bus_q.push_back(eb);
      if (has_rsp) rsp_q.push_back(e);
      @(negedge clk);
      bus.req_valid_i = 1'b0;
    end
  endtask

  // Bus responder and bus-side monitor. Every cycle with mem_req_o is
  // compared against the expected access, which also covers field stability
  // while the grant is held back. The expectation is popped when granting.
  initial begin
    int  req_wait;
    int  rsp_wait;
    bit  in_rsp;
    req_wait = 0; rsp_wait = 0; in_rsp = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (!rst_ni || bus.done_o) begin
        in_rsp   = 1'b0;
        req_wait = 0;
      end
      if (bus.mem_req_o) begin
        if (bus_q.size() == 0) begin
          check("unexpected_mem_req", 32'(bus.mem_req_o), 32'd0);
        end else begin
          check("mem_we",    32'(bus.mem_we_o), 32'(bus_q[0].we));
          check("mem_addr",  bus.mem_addr_o,    bus_q[0].addr);
          check("mem_be",    32'(bus.mem_be_o), 32'(bus_q[0].be));
          check("mem_wdata", bus.mem_wdata_o,   bus_q[0].wdata);
        end
        if (req_wait == gnt_delay) begin
          bus.mem_gnt_i = 1'b1;
          req_wait = 0;
          in_rsp   = 1'b1;
          rsp_wait = 0;
          if (bus_q.size() != 0) void'(bus_q.pop_front());
        end else begin
          req_wait++;
        end
      end else if (in_rsp) begin
        if (rsp_delay >= 0 && rsp_wait == rsp_delay) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rsp_data;
          in_rsp = 1'b0;
        end else begin
          rsp_wait++;
        end
      end
      if (stray_rvalid) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'hFFFF_FFFF;
      end
    end
  end

  // Retire monitor: each done_o pulse is matched against the next expected result
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (bus.done_o) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_done", 32'(bus.done_o), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("exc_valid", 32'(bus.exc_valid_o), 32'(e.exc));
          if (e.exc) begin
            check("exc_cause", 32'(bus.exc_cause_o), 32'(e.cause));
            check("exc_addr",  bus.exc_addr_o,       e.eaddr);
          end
          check("wb_valid", 32'(bus.wb_valid_o), 32'(e.wb));
          if (e.wb) begin
            check("wb_rd",   32'(bus.wb_rd_o), 32'(e.rd));
            check("wb_data", bus.wb_data_o,    e.data);
          end
        end
      end else if (bus.wb_valid_o || bus.exc_valid_o) begin
        check("pulse_outside_done", 32'({bus.wb_valid_o, bus.exc_valid_o}), 32'd0);
      end
    end
  end

  initial begin
    int waited;
    rst_ni             = 1'b0;
    bus.req_valid_i    = 1'b0;
    bus.req_we_i       = 1'b0;
    bus.req_size_i     = '0;
    bus.req_unsigned_i = 1'b0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;
    bus.req_rd_i       = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ready",     32'(bus.req_ready_o), 32'd1);
    check("rst_mem_req",   32'(bus.mem_req_o),   32'd0);
    check("rst_mem_addr",  bus.mem_addr_o,       32'd0);
    check("rst_mem_be",    32'(bus.mem_be_o),    32'd0);
    check("rst_done",      32'(bus.done_o),      32'd0);
    check("rst_wb_valid",  32'(bus.wb_valid_o),  32'd0);
    check("rst_exc_valid", 32'(bus.exc_valid_o), 32'd0);
    check("rst_wb_data",   bus.wb_data_o,        32'd0);
    check("rst_exc_cause", 32'(bus.exc_cause_o), 32'd0);
    rst_ni = 1'b1;

    // LB 0x103, sign-extended byte 3 of 0x80123456
    cfg(0, 0, 32'h8012_3456);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 5'd5, 3,
          1'b1, b(1'b0, 32'h100, 4'b1000, 32'h0), 1'b1, r_ok(1'b1, 5'd5, 32'hFFFF_FF80));
    // SH 0x202: upper half lanes, replicated data, no writeback
    cfg(0, 0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 5'd7, 3,
          1'b1, b(1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF), 1'b1, r_ok(1'b0, 5'd0, 32'h0));
    // LW 0x106: misaligned, no bus access, retires next cycle
    cfg(0, 0, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0106, 32'h0, 5'd3, 1,
          1'b0, b(1'b0, 32'h0, 4'h0, 32'h0), 1'b1, r_exc(2'b01, 32'h106));
    // LBU 0x101: byte 1 = 0xC5 zero-extended
    cfg(0, 0, 32'h0000_C500);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0, 5'd1, 3,
          1'b1, b(1'b0, 32'h100, 4'b0010, 32'h0), 1'b1, r_ok(1'b1, 5'd1, 32'h0000_00C5));
    // LH 0x42: upper half 0x8001 sign-extended
    cfg(0, 0, 32'h8001_1234);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0, 5'd31, 3,
          1'b1, b(1'b0, 32'h40, 4'b1100, 32'h0), 1'b1, r_ok(1'b1, 5'd31, 32'hFFFF_8001));
    // LHU 0x40: lower half 0xF00D zero-extended
    cfg(0, 0, 32'h8001_F00D);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0040, 32'h0, 5'd4, 3,
          1'b1, b(1'b0, 32'h40, 4'b0011, 32'h0), 1'b1, r_ok(1'b1, 5'd4, 32'h0000_F00D));
    // LW to x0: retires without a writeback pulse
    cfg(0, 0, 32'hDEAD_BEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 5'd0, 3,
          1'b1, b(1'b0, 32'h1000, 4'b1111, 32'h0), 1'b1, r_ok(1'b0, 5'd0, 32'h0));
    // SB 0x303: lane 3, byte replicated
    cfg(0, 0, 32'h0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0303, 32'hFFFF_FFA5, 5'd8, 3,
          1'b1, b(1'b1, 32'h300, 4'b1000, 32'hA5A5_A5A5), 1'b1, r_ok(1'b0, 5'd0, 32'h0));
    // SW with grant withheld 5 cycles: fields checked every REQ cycle
    cfg(5, 0, 32'h0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hCAFE_F00D, 5'd9, 8,
          1'b1, b(1'b1, 32'h400, 4'b1111, 32'hCAFE_F00D), 1'b1, r_ok(1'b0, 5'd0, 32'h0));
    // Illegal size with an unaligned address: illegal size has priority
    cfg(0, 0, 32'h0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0503, 32'h0, 5'd2, 1,
          1'b0, b(1'b0, 32'h0, 4'h0, 32'h0), 1'b1, r_exc(2'b11, 32'h503));
    // SH at an odd address: misaligned store
    cfg(0, 0, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0201, 32'h1234, 5'd2, 1,
          1'b0, b(1'b0, 32'h0, 4'h0, 32'h0), 1'b1, r_exc(2'b01, 32'h201));
    // LW with no response: timeout after 4 RSP cycles
    cfg(0, -1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0600, 32'h0, 5'd6, 6,
          1'b1, b(1'b0, 32'h600, 4'b1111, 32'h0), 1'b1, r_exc(2'b10, 32'h600));
    // LW answered in the last allowed RSP cycle: the response wins
    cfg(0, 3, 32'h1122_3344);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0604, 32'h0, 5'd9, 6,
          1'b1, b(1'b0, 32'h604, 4'b1111, 32'h0), 1'b1, r_ok(1'b1, 5'd9, 32'h1122_3344));

    // Reset while waiting for a response: no retire, stray rvalid ignored
    cfg(0, -1, 32'h0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0700, 32'h0, 5'd10, 0,
          1'b1, b(1'b0, 32'h700, 4'b1111, 32'h0), 1'b0, r_ok(1'b0, 5'd0, 32'h0));
    @(negedge clk);                 // DUT is in RSP here
    rst_ni = 1'b0;
    @(negedge clk);
    check("midrst_ready",     32'(bus.req_ready_o), 32'd1);
    check("midrst_mem_req",   32'(bus.mem_req_o),   32'd0);
    check("midrst_wb_data",   bus.wb_data_o,        32'd0);
    check("midrst_exc_cause", 32'(bus.exc_cause_o), 32'd0);
    rst_ni = 1'b1;
    stray_rvalid = 1'b1;
    @(negedge clk);
    stray_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ready",   32'(bus.req_ready_o), 32'd1);
    check("stray_wb_data", bus.wb_data_o,        32'd0);

    // Normal operation after reset: LB 0x000, byte 0x7F positive
    cfg(0, 0, 32'h0000_007F);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0000, 32'h0, 5'd2, 3,
          1'b1, b(1'b0, 32'h0, 4'b0001, 32'h0), 1'b1, r_ok(1'b1, 5'd2, 32'h0000_007F));

    // Drain the scoreboard
    waited = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32im_dmem_if.md
RV32IM_DMEM_IF -- requirements
Module: rv32im_dmem_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of cycles spent waiting for a response before a bus-timeout exception.
REQ-002 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_ni  in  1  reset, synchronous, active-low.
REQ-004 req_valid_i  in  1  execute-stage memory request valid.
REQ-005 req_ready_o  out  1  block can accept a request.
REQ-006 req_we_i  in  1  1 = store, 0 = load.
REQ-007 req_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 req_unsigned_i  in  1  load is zero-extended (LBU/LHU).
REQ-009 req_addr_i  in  32  byte address computed by the execute stage.
REQ-010 req_wdata_i  in  32  store data (rs2), right-aligned.
REQ-011 req_rd_i  in  5  destination register index.
REQ-012 mem_req_o  out  1  bus request valid.
REQ-013 mem_gnt_i  in  1  bus accepts the request this cycle.
REQ-014 mem_we_o  out  1  bus write enable.
REQ-015 mem_addr_o  out  32  word-aligned address, bits [1:0] = 00.
REQ-016 mem_be_o  out  4  byte lane enables.
REQ-017 mem_wdata_o  out  32  lane-aligned write data.
REQ-018 mem_rvalid_i  in  1  bus response valid.
REQ-019 mem_rdata_i  in  32  bus read data, full word.
REQ-020 wb_valid_o  out  1  one-cycle pulse: load result valid.
REQ-021 wb_rd_o  out  5  writeback register index.
REQ-022 wb_data_o  out  32  extended load data.
REQ-023 done_o  out  1  one-cycle pulse: operation retired (load, store or exception).
REQ-024 exc_valid_o  out  1  one-cycle pulse: exception.
REQ-025 exc_cause_o  out  2  01 misaligned, 10 bus timeout, 11 illegal size.
REQ-026 exc_addr_o  out  32  faulting byte address.

Function
REQ-027 FSM states: IDLE, REQ, RSP, DONE; req_ready_o = 1 only in IDLE.
REQ-028 Handshake: a request is accepted on the cycle req_valid_i and req_ready_o are both 1; all request fields are registered on acceptance.
REQ-029 Acceptance check: size 11 gives illegal-size; half with addr[0]=1 or word with addr[1:0]≠00 gives misaligned. Illegal size takes priority over misaligned.
REQ-030 A failed check goes IDLE->DONE with the exception; no bus request is issued.
REQ-031 A passing request goes IDLE->REQ.
REQ-032 In REQ: mem_req_o=1 and mem_we_o/addr/be/wdata are held stable until mem_gnt_i; on grant go to RSP.
REQ-033 Byte lanes: byte be=0001<<addr[1:0], wdata={4{wdata[7:0]}}; half be=0011<<(2*addr[1]), wdata={2{wdata[15:0]}}; word be=1111, wdata unchanged. Loads use the same be.
REQ-034 In RSP: wait for mem_rvalid_i; mem_rvalid_i is ignored in every other state.
REQ-035 In RSP: an 8-bit counter clears on entry and increments each cycle without rvalid; on reaching TIMEOUT_CYCLES go to DONE with a bus-timeout exception.
REQ-036 If rvalid arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the response wins.
REQ-037 On rvalid, load data: select the byte at addr[1:0] or the half at addr[1]; sign-extend, or zero-extend if unsigned; register it; go to DONE.
REQ-038 DONE lasts one cycle, then returns to IDLE.
REQ-039 In DONE: done_o=1. exc_valid_o=1 if an exception occurred. Otherwise wb_valid_o=1 for loads with rd≠0.
REQ-040 Latency, accept at cycle T with immediate grant and rvalid: mem_req_o at T+1, RSP at T+2, done_o at T+3. Minimum issue interval is 4 cycles.
REQ-041 wb_data_o, wb_rd_o and exc_* hold their last value outside DONE. Consumers qualify them with the valid pulses.

Reset
REQ-042 Reset, rst_ni=0 sampled on a clock edge, takes priority over all other behaviour: state=IDLE, counter=0, all outputs 0 except req_ready_o=1. This applies mid-transaction; the bus request is dropped and no done_o is produced.

Verification
REQ-043 LB addr 0x103, rdata 0x80xxxxxx, immediate gnt/rvalid -> mem_addr_o 0x100, be 1000, wb_data_o 0xFFFFFF80, done_o at T+3.
REQ-044 SH addr 0x202, wdata 0x0000BEEF -> mem_we_o=1, be 1100, mem_wdata_o 0xBEEFBEEF, done_o=1, wb_valid_o=0.
REQ-045 LW addr 0x106 -> no mem_req_o, exc_cause_o=01, exc_addr_o 0x106, done_o at T+1.
REQ-046 Grant withheld 5 cycles -> mem_req_o and fields stable throughout. Rvalid never asserted with TIMEOUT_CYCLES=4 -> exc_cause_o=10.
REQ-047 rst_ni=0 while in RSP -> next cycle req_ready_o=1, mem_req_o=0. A late rvalid is ignored.
